// File: rtl/uart_wb_host_pkg.sv
// Shared constants and state encoding for the uart_wb_host register-port master.
package uart_wb_pkg;

  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  typedef enum logic [3:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    INIT_IER,
    POLL,
    RD_RBR,
    WR_THR
  } state_t;

endpackage

// File: rtl/uart_wb_host_if.sv
// Wishbone register-port bundle between the host block and the uart_top core.
interface uart_wb_host_if;

  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o,
    output wb_stb_o, wb_cyc_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o,
    input  wb_stb_o, wb_cyc_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/uart_wb_host_xact.sv
// Single Wishbone transaction engine: holds the bus until ack or timeout,
// then inserts one idle cycle before accepting the next start.
module uart_wb_xact
  import uart_wb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     adr,
  input  logic [7:0]     dat,
  input  logic           we,
  uart_wb_host_if.master bus,
  output logic           done,
  output logic [7:0]     rdata,
  output logic           timeout
);

  logic       stb;
  logic       gap;
  logic [7:0] cnt;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       we_q;
  logic       ack;

  assign ack     = stb && bus.wb_ack_i;
  assign timeout = stb && !bus.wb_ack_i
                && (cnt == TIMEOUT - 8'd1);
  assign done    = ack || timeout;
  assign rdata   = ack ? bus.wb_dat_i : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      stb   <= 1'b0;
      gap   <= 1'b0;
      cnt   <= 8'd0;
      adr_q <= 3'd0;
      dat_q <= 8'd0;
      we_q  <= 1'b0;
    end else if (stb) begin
      if (done) begin
        stb <= 1'b0;
        gap <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else if (gap) begin
      gap <= 1'b0;
    end else if (start) begin
      stb   <= 1'b1;
      cnt   <= 8'd0;
      adr_q <= adr;
      dat_q <= dat;
      we_q  <= we;
    end
  end

  assign bus.wb_stb_o = stb;
  assign bus.wb_cyc_o = stb;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_sel_o = 4'b0001;

endmodule

// File: rtl/uart_wb_host.sv
// Wishbone master that initialises a 16550 core and then polls LSR,
// streaming RX bytes out and TX bytes in through a one-byte buffer.
module uart_wb_host
  import uart_wb_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd16,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  uart_wb_host_if.master wb,
  input  logic [7:0]     tx_data_i,
  input  logic           tx_valid_i,
  output logic           tx_ready_o,
  output logic [7:0]     rx_data_o,
  output logic           rx_valid_o,
  output logic           init_done_o,
  output logic           err_o
);

  state_t     state;
  state_t     state_n;
  logic [2:0] adr;
  logic [7:0] dat;
  logic       we;
  logic       done;
  logic       timeout;
  logic [7:0] rdata;
  logic       full;
  logic       full_n;
  logic       init_n;
  logic [7:0] tx_byte;
  logic       capture;

  assign capture = tx_valid_i && tx_ready_o;

  uart_wb_xact #(
    .TIMEOUT (TIMEOUT)
  ) u_xact (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .start   (1'b1),
    .adr     (adr),
    .dat     (dat),
    .we      (we),
    .bus     (wb),
    .done    (done),
    .rdata   (rdata),
    .timeout (timeout)
  );

  always_comb begin
    adr     = REG_LSR;
    dat     = 8'h00;
    we      = 1'b0;
    state_n = state;
    unique case (state)
      INIT_LCR_DLAB: begin
        adr = REG_LCR; dat = LCR_VAL | 8'h80; we = 1'b1;
        if (done) state_n = INIT_DLL;
      end
      INIT_DLL: begin
        adr = REG_DLL; dat = DIVISOR[7:0]; we = 1'b1;
        if (done) state_n = INIT_DLM;
      end
      INIT_DLM: begin
        adr = REG_DLM; dat = DIVISOR[15:8]; we = 1'b1;
        if (done) state_n = INIT_LCR;
      end
      INIT_LCR: begin
        adr = REG_LCR; dat = LCR_VAL & 8'h7F; we = 1'b1;
        if (done) state_n = INIT_FCR;
      end
      INIT_FCR: begin
        adr = REG_FCR; dat = FCR_VAL; we = 1'b1;
        if (done) state_n = INIT_IER;
      end
      INIT_IER: begin
        adr = REG_IER; we = 1'b1;
        if (done) state_n = POLL;
      end
      POLL: begin
        // receive side wins when both directions are serviceable
        if (done) begin
          if (rdata[LSR_DR])
            state_n = RD_RBR;
          else if (full && rdata[LSR_THRE])
            state_n = WR_THR;
        end
      end
      RD_RBR: begin
        adr = REG_RBR;
        if (done) state_n = POLL;
      end
      WR_THR: begin
        adr = REG_THR; dat = tx_byte; we = 1'b1;
        if (done) state_n = POLL;
      end
      default: state_n = INIT_LCR_DLAB;
    endcase
  end

  always_comb begin
    init_n = init_done_o || (state == INIT_IER && done);
    full_n = full;
    if (capture)
      full_n = 1'b1;
    else if (state == WR_THR && done)
      full_n = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= INIT_LCR_DLAB;
      full        <= 1'b0;
      tx_byte     <= 8'h00;
      tx_ready_o  <= 1'b0;
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      full        <= full_n;
      tx_ready_o  <= init_n && !full_n;
      init_done_o <= init_n;
      err_o       <= err_o || timeout;
      rx_valid_o  <= (state == RD_RBR) && done;
      if (capture)
        tx_byte <= tx_data_i;
      if (state == RD_RBR && done)
        rx_data_o <= rdata;
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Randomised bench for uart_wb_host with a transaction-level reference model.
module tb_uart_wb_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       init_done;
  logic       err;

  uart_wb_host_if bus ();

  uart_wb_host dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (bus),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .init_done_o (init_done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  // hand-derived init writes {adr, dat} for DIVISOR=16, LCR=03, FCR=07
  logic [10:0] ini_tbl [6] = '{
    {3'd3, 8'h83}, {3'd0, 8'h10}, {3'd1, 8'h00},
    {3'd3, 8'h03}, {3'd2, 8'h07}, {3'd1, 8'h00}
  };

  // responder knobs
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  int         lat_max = 1;
  bit         no_ack = 1'b0;
  bit         stray_en = 1'b0;
  int         age = 0;
  int         lat = 1;

  always begin
    @(posedge clk);
    #1;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 8'($urandom);
    if (bus.wb_stb_o) begin
      age++;
      if (age == 1) lat = int'($urandom_range(lat_max, 1));
      if (!no_ack && age == lat + 1) begin
        bus.wb_ack_i = 1'b1;
        if (bus.wb_adr_o == 3'd5) bus.wb_dat_i = lsr_val;
        else if (bus.wb_adr_o == 3'd0 && !bus.wb_we_o)
          bus.wb_dat_i = rbr_val;
      end
    end else begin
      age = 0;
      if (stray_en && $urandom_range(5, 0) == 0) bus.wb_ack_i = 1'b1;
    end
  end

  // reference model: phase 0..5 init writes, 6 poll, 7 rbr read, 8 thr write
  int          phase = 0;
  int          wait_n = 0;
  int          m_age = 0;
  bit          pend = 1'b0;
  logic [7:0]  pbyte = 8'h00;
  logic [7:0]  rd;
  bit          cap;
  bit          clr;
  logic        e_stb = 1'b0;
  logic [2:0]  e_adr = 3'd0;
  logic [7:0]  e_dat = 8'h00;
  logic        e_we = 1'b0;
  logic        e_ready = 1'b0;
  logic        e_rxv = 1'b0;
  logic [7:0]  e_rxd = 8'h00;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;

  logic [10:0] wlog [$];
  int          rise_cyc [$];
  int          cyc_n = 0;
  int          run = 0;
  int          last_run = 0;
  int          rx_count = 0;
  logic        prev_stb = 1'b0;

  always @(negedge clk) begin
    chk("stb", 32'(bus.wb_stb_o), 32'(e_stb));
    chk("cyc", 32'(bus.wb_cyc_o), 32'(e_stb));
    chk("sel", 32'(bus.wb_sel_o), 32'h1);
    chk("tx_ready", 32'(tx_ready), 32'(e_ready));
    chk("rx_valid", 32'(rx_valid), 32'(e_rxv));
    chk("rx_data", 32'(rx_data), 32'(e_rxd));
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    if (e_stb) begin
      chk("adr", 32'(bus.wb_adr_o), 32'(e_adr));
      chk("we", 32'(bus.wb_we_o), 32'(e_we));
      if (e_we) chk("wdat", 32'(bus.wb_dat_o), 32'(e_dat));
    end

    if (bus.wb_stb_o && !prev_stb) begin
      rise_cyc.push_back(cyc_n);
      if (bus.wb_we_o) wlog.push_back({bus.wb_adr_o, bus.wb_dat_o});
    end
    if (bus.wb_stb_o) run++;
    else if (prev_stb) begin
      last_run = run;
      run = 0;
    end
    prev_stb = bus.wb_stb_o;
    if (rx_valid) rx_count++;

    if (rst) begin
      e_stb = 1'b0; wait_n = 0; phase = 0; pend = 1'b0;
      e_ready = 1'b0; e_rxv = 1'b0; e_rxd = 8'h00;
      e_done = 1'b0; e_err = 1'b0;
    end else begin
      cap = tx_valid && e_ready;
      clr = 1'b0;
      e_rxv = 1'b0;
      if (e_stb) begin
        m_age++;
        if (bus.wb_ack_i || m_age == 255) begin
          rd = bus.wb_ack_i ? bus.wb_dat_i : 8'h00;
          if (!bus.wb_ack_i) e_err = 1'b1;
          case (phase)
            5: begin phase = 6; e_done = 1'b1; end
            6: phase = rd[0] ? 7 : ((pend && rd[5]) ? 8 : 6);
            7: begin e_rxd = rd; e_rxv = 1'b1; phase = 6; end
            8: begin clr = 1'b1; phase = 6; end
            default: phase++;
          endcase
          e_stb = 1'b0;
          wait_n = 1;
        end
      end else if (wait_n == 0) begin
        e_stb = 1'b1;
        m_age = 0;
        if (phase < 6) begin
          {e_adr, e_dat} = ini_tbl[phase];
          e_we = 1'b1;
        end else if (phase == 6) begin
          e_adr = 3'd5; e_dat = 8'h00; e_we = 1'b0;
        end else if (phase == 7) begin
          e_adr = 3'd0; e_dat = 8'h00; e_we = 1'b0;
        end else begin
          e_adr = 3'd0; e_dat = pbyte; e_we = 1'b1;
        end
      end else begin
        wait_n--;
      end
      if (cap) begin pend = 1'b1; pbyte = tx_data; end
      if (clr) pend = 1'b0;
      e_ready = e_done && !pend;
    end
    cyc_n++;
  end

  bit ok;
  int n0;

  task automatic send(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = tx_ready;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_handshake", 32'(got), 32'h1);
  endtask

  task automatic wait_write(input int n, input int budget);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      ok = (wlog.size() > n);
    end
    chk("write_wait", 32'(ok), 32'h1);
  endtask

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // init sequence against a 1-cycle-ack responder
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = init_done;
    end
    chk("init_wait", 32'(ok), 32'h1);
    repeat (2) @(posedge clk);
    chk("init_count", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("init_write", 32'(wlog[i]), 32'(ini_tbl[i]));
    for (int i = 0; i < 5 && i + 1 < rise_cyc.size(); i++)
      chk("stb_spacing", 32'(rise_cyc[i+1] - rise_cyc[i]), 32'd4);

    // rx has priority over a pending tx byte
    send(8'h33);
    lsr_val = 8'h21;
    rbr_val = 8'hA5;
    n0 = wlog.size();
    repeat (60) @(posedge clk);
    chk("rx_seen", 32'(rx_count > 0), 32'h1);
    chk("rx_byte", 32'(rx_data), 32'hA5);
    chk("no_thr_while_rx", 32'(wlog.size()), 32'(n0));
    lsr_val = 8'h20;
    wait_write(n0, 40);
    if (wlog.size() > n0) chk("thr_33", 32'(wlog[n0]), 32'h033);

    // plain tx handshake
    repeat (5) @(posedge clk);
    n0 = wlog.size();
    send(8'h5A);
    @(negedge clk);
    chk("ready_drop", 32'(tx_ready), 32'h0);
    wait_write(n0, 40);
    if (wlog.size() > n0) chk("thr_5a", 32'(wlog[n0]), 32'h05A);
    repeat (6) @(negedge clk);
    chk("ready_back", 32'(tx_ready), 32'h1);

    // THRE low holds the pending byte
    lsr_val = 8'h00;
    n0 = wlog.size();
    send(8'h77);
    repeat (60) @(posedge clk);
    chk("no_thr_thre0", 32'(wlog.size()), 32'(n0));
    lsr_val = 8'h20;
    wait_write(n0, 40);
    if (wlog.size() > n0) chk("thr_77", 32'(wlog[n0]), 32'h077);

    // ack timeout
    repeat (4) @(posedge clk);
    no_ack = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = err;
    end
    chk("err_wait", 32'(ok), 32'h1);
    no_ack = 1'b0;
    repeat (3) @(posedge clk);
    chk("timeout_len", 32'(last_run), 32'd255);
    repeat (30) @(posedge clk);
    chk("err_sticky", 32'(err), 32'h1);

    // randomised traffic
    lat_max = 3;
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ((i % 8) == 0) lsr_val = 8'($urandom);
      rbr_val = 8'($urandom);
      tx_valid = ($urandom_range(2, 0) == 0);
      tx_data = 8'($urandom);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    stray_en = 1'b0;
    lsr_val = 8'h00;

    // reset while the INIT_DLM write is on the bus
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wlog.delete();
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      ok = (wlog.size() == 3);
    end
    chk("dlm_wait", 32'(ok), 32'h1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    wlog.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'h0);
    wait_write(0, 40);
    if (wlog.size() > 0) chk("restart_write", 32'(wlog[0]), 32'h383);
    repeat (40) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/uart_wb_host.md
# uart_wb_host

Wishbone initiator that owns the register port of the 16550-compatible `uart_top` core (8-bit data-bus build) on the Tiny Tapeout top level. After reset it programs divisor, line control and FIFO control. It then loops polling LSR: it drains received bytes to a valid-pulse output and pushes user bytes into THR with a valid/ready handshake. The block gives the chip a byte-stream UART without any external bus master.

## Interface
- `DIVISOR`, 16'd16: baud divisor written to DLM:DLL.
- `LCR_VAL`, 8'h03: line control value (8N1); DLAB (bit 7) is forced by the block.
- `FCR_VAL`, 8'h07: FIFO control value (enable, clear RX/TX FIFOs).
- `TIMEOUT`, 8'd255: cycles to wait for `wb_ack_i` before aborting a transaction.

Ports:
- `wb_clk_i`, in, 1: clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-high.
- `wb_adr_o`, out, 3: register address.
- `wb_dat_o`, out, 8: write data.
- `wb_dat_i`, in, 8: read data, sampled on the `wb_ack_i` cycle.
- `wb_we_o`, out, 1: write enable.
- `wb_stb_o`, out, 1: strobe.
- `wb_cyc_o`, out, 1: cycle; always equal to `wb_stb_o`.
- `wb_sel_o`, out, 4: constant 4'b0001.
- `wb_ack_i`, in, 1: acknowledge.
- `tx_data_i`, in, 8: byte to transmit.
- `tx_valid_i`, in, 1: tx byte offered.
- `tx_ready_o`, out, 1: 1-byte tx buffer empty.
- `rx_data_o`, out, 8: last received byte; held until the next receive.
- `rx_valid_o`, out, 1: one-cycle pulse when `rx_data_o` updates.
- `init_done_o`, out, 1: set when the init sequence completes.
- `err_o`, out, 1: sticky flag; set on any ack timeout.

## Operation
- **Reset values.** All outputs 0 except `wb_sel_o` = 4'b0001. State = INIT_LCR_DLAB. TX buffer empty, but `tx_ready_o` stays 0 until `init_done_o` is 1.
- **Init sequence.** Each step is one write:
  - INIT_LCR_DLAB: adr 3, data `LCR_VAL|8'h80`.
  - INIT_DLL: adr 0, data `DIVISOR[7:0]`.
  - INIT_DLM: adr 1, data `DIVISOR[15:8]`.
  - INIT_LCR: adr 3, data `LCR_VAL&8'h7F`.
  - INIT_FCR: adr 2, data `FCR_VAL`.
  - INIT_IER: adr 1, data 8'h00.
  - Then go to POLL and set `init_done_o`.
- **POLL.** Read LSR (adr 5). On completion:
  - If LSR[0]=1: go to RD_RBR (read adr 0).
  - Else if the tx buffer is full and LSR[5]=1: go to WR_THR (write adr 0 with the buffered byte).
  - Else: go to POLL again.
  - RX has priority over TX.
- **RD_RBR completion.** `rx_data_o` ← `wb_dat_i`; pulse `rx_valid_o`; go to POLL.
- **WR_THR completion.** Clear the tx buffer; go to POLL.
- **TX handshake.** The byte is captured when `tx_valid_i && tx_ready_o`. `tx_ready_o` falls the next cycle and rises the cycle after the WR_THR ack. A capture and a buffer clear never coincide, because ready is 0 while the buffer is full.
- **Timeout.**
  - An 8-bit counter counts stb-high cycles.
  - When the count reaches `TIMEOUT` with no ack, the block drops stb/cyc, sets `err_o`, and treats the transaction as complete with read data 8'h00.
  - With data 8'h00, LSR bits read as 0, so no rx pulse is generated. A timed-out WR_THR still clears the buffer (the byte is dropped).
  - Init continues through timeouts.
- **Reset mid-transaction.** Drop stb/cyc in the next cycle and restart init from INIT_LCR_DLAB. `err_o` is cleared.

## Timing
- All outputs are registered.
- A transaction asserts adr/dat/we/stb/cyc together and holds them stable until the ack cycle inclusive. Stb is 0 in the cycle after ack, and for one more idle cycle before the next stb.
- Minimum spacing, ack-to-next-stb: 2 cycles.
- With a 1-cycle-ack responder (ack in the cycle after stb rises), each transaction occupies 4 cycles stb-rise to stb-rise.
- Init takes 6 transactions. `init_done_o` rises in the cycle after the INIT_IER ack.
- `rx_valid_o` pulses in the cycle after the RD_RBR ack.
- An ack arriving while stb=0 is ignored.

## Structure
- Package `uart_wb_pkg` holds:
  - register address constants: RBR/THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, LSR=5;
  - LSR bit indices: DR=0, THRE=5;
  - the state enum (INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, INIT_IER, POLL, RD_RBR, WR_THR).
- Sub-module `uart_wb_xact` is a single-transaction engine: start/adr/dat/we in; stb/cyc/ack handling, timeout counter, done/rdata/timeout out. The top-level FSM sequences `uart_wb_xact`.

## Test plan
- **Reset then 1-cycle-ack model.** Expect writes in order (3,8'h83), (0,8'h10), (1,8'h00), (3,8'h03), (2,8'h07), (1,8'h00). `init_done_o` rises 1 cycle after the 6th ack. Stb-rise spacing is 4 cycles.
- **LSR returns 8'h21, RBR returns 8'hA5.** Expect `rx_valid_o` for 1 cycle with `rx_data_o`=8'hA5. RBR is read before THR is written, even with a tx byte pending.
- **`tx_data_i`=8'h5A offered, LSR=8'h20.** `tx_ready_o` drops, a write (0,8'h5A) is issued, and `tx_ready_o` returns 1 the cycle after that ack.
- **LSR=8'h00 with tx pending.** No THR write while THRE=0. Once LSR changes to 8'h20, the THR write is issued on the next poll.
- **Responder never acks the LSR read.** Stb drops after 255 cycles, `err_o`=1 (sticky), and polling resumes.
- **`wb_rst_i` asserted while stb is high during INIT_DLM.** Stb=0 next cycle, `err_o`=0, and init restarts with (3,8'h83).
